lw_sha_padder: RTL and testbench

LW_SHA_PADDER -- requirements
Module: lw_sha_padder

---
 rtl/lw_sha_padder.sv | 171 +++++++++++++++++
 tb/tb_lw_sha_padder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_sha_padder.sv
// rtl/lw_sha_padder.sv - SHA-224/256 message padder feeding a word-serial hash core
// Appends the 0x80 terminator, zero fill and 64-bit bit length to a big-endian word stream.
module lw_sha_padder (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        msg_start_i,
  input  logic        opcode_i,
  input  logic        msg_valid_i,
  input  logic [31:0] msg_data_i,
  input  logic        msg_last_i,
  input  logic [2:0]  msg_nbytes_i,
  output logic        msg_ready_o,
  input  logic        abort_i,
  input  logic        core_ready_i,
  input  logic        word_ready_i,
  output logic        start_o,
  output logic        data_valid_o,
  output logic        last_o,
  output logic        abort_o,
  output logic [31:0] data_o,
  output logic        opcode_o
);

  typedef enum logic [2:0] {IDLE, MSG, PAD, LEN_HI, LEN_LO} state_t;

  state_t      state;
  logic [60:0] byte_cnt;
  logic [3:0]  widx;
  logic        first_pend;
  logic        term_pend;
  logic        final_blk;

  logic        xfer;
  logic        can_load;
  logic        msg_take;
  logic [3:0]  load_idx;
  logic [31:0] tail_word;
  logic [60:0] nb_add;
  logic [63:0] bit_len;

  // widx counts transfers; a word loaded in the same cycle as a transfer takes the next slot
  assign xfer        = data_valid_o && word_ready_i;
  assign can_load    = !data_valid_o || word_ready_i;
  assign load_idx    = xfer ? (widx + 4'd1) : widx;
  assign msg_ready_o = (state == MSG) && can_load;
  assign msg_take    = msg_valid_i && msg_ready_o;
  assign bit_len     = {byte_cnt, 3'b000};
  assign nb_add      = msg_nbytes_i[2] ? 61'd4 : {58'd0, msg_nbytes_i};

  always_comb begin
    tail_word = 32'h8000_0000;
    case (msg_nbytes_i)
      3'd1:    tail_word = {msg_data_i[31:24], 24'h80_0000};
      3'd2:    tail_word = {msg_data_i[31:16], 16'h8000};
      3'd3:    tail_word = {msg_data_i[31:8], 8'h80};
      default: tail_word = 32'h8000_0000;
    endcase
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      widx         <= '0;
      first_pend   <= 1'b0;
      term_pend    <= 1'b0;
      final_blk    <= 1'b0;
      start_o      <= 1'b0;
      data_valid_o <= 1'b0;
      last_o       <= 1'b0;
      abort_o      <= 1'b0;
      data_o       <= '0;
      opcode_o     <= 1'b0;
    end else begin
      abort_o <= 1'b0;
      if ((state != IDLE) && abort_i) begin
        state        <= IDLE;
        data_valid_o <= 1'b0;
        start_o      <= 1'b0;
        last_o       <= 1'b0;
        abort_o      <= 1'b1;
        first_pend   <= 1'b0;
        term_pend    <= 1'b0;
        final_blk    <= 1'b0;
      end else begin
        if (xfer) begin
          widx    <= widx + 4'd1;
          start_o <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (msg_start_i && core_ready_i) begin
              state      <= MSG;
              opcode_o   <= opcode_i;
              byte_cnt   <= '0;
              widx       <= '0;
              first_pend <= 1'b1;
              term_pend  <= 1'b0;
              final_blk  <= 1'b0;
            end
          end
          MSG: begin
            if (msg_take) begin
              data_valid_o <= 1'b1;
              start_o      <= first_pend;
              first_pend   <= 1'b0;
              if (!msg_last_i) begin
                data_o   <= msg_data_i;
                byte_cnt <= byte_cnt + 61'd4;
                last_o   <= 1'b0;
              end else if (msg_nbytes_i[2]) begin
                // full final word: the terminator goes out as its own word from PAD
                data_o    <= msg_data_i;
                byte_cnt  <= byte_cnt + nb_add;
                last_o    <= 1'b0;
                term_pend <= 1'b1;
                state     <= PAD;
              end else begin
                data_o    <= tail_word;
                byte_cnt  <= byte_cnt + nb_add;
                last_o    <= (load_idx <= 4'd13);
                final_blk <= (load_idx <= 4'd13);
                state     <= PAD;
              end
            end else if (xfer) begin
              data_valid_o <= 1'b0;
            end
          end
          PAD: begin
            if (xfer) begin
              data_valid_o <= 1'b1;
              if (term_pend) begin
                data_o    <= 32'h8000_0000;
                term_pend <= 1'b0;
                last_o    <= (load_idx <= 4'd13);
                final_blk <= (load_idx <= 4'd13);
              end else if (final_blk && (load_idx == 4'd14)) begin
                data_o <= bit_len[63:32];
                last_o <= 1'b1;
                state  <= LEN_HI;
              end else begin
                data_o <= '0;
                // slot 0 of an overflow block starts the final block
                if (load_idx == 4'd0) begin
                  final_blk <= 1'b1;
                  last_o    <= 1'b1;
                end
              end
            end
          end
          LEN_HI: begin
            if (xfer) begin
              data_o <= bit_len[31:0];
              state  <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (xfer) begin
              data_valid_o <= 1'b0;
              last_o       <= 1'b0;
              final_blk    <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lw_sha_padder.sv
// tb/tb_lw_sha_padder.sv - directed bench for lw_sha_padder with an expected-word scoreboard
module tb_lw_sha_padder;

  logic        clk_i;
  logic        aresetn_i;
  logic        msg_start_i;
  logic        opcode_i;
  logic        msg_valid_i;
  logic [31:0] msg_data_i;
  logic        msg_last_i;
  logic [2:0]  msg_nbytes_i;
  logic        msg_ready_o;
  logic        abort_i;
  logic        core_ready_i;
  logic        word_ready_i;
  logic        start_o;
  logic        data_valid_o;
  logic        last_o;
  logic        abort_o;
  logic [31:0] data_o;
  logic        opcode_o;

  lw_sha_padder dut (
    .clk_i        (clk_i),
    .aresetn_i    (aresetn_i),
    .msg_start_i  (msg_start_i),
    .opcode_i     (opcode_i),
    .msg_valid_i  (msg_valid_i),
    .msg_data_i   (msg_data_i),
    .msg_last_i   (msg_last_i),
    .msg_nbytes_i (msg_nbytes_i),
    .msg_ready_o  (msg_ready_o),
    .abort_i      (abort_i),
    .core_ready_i (core_ready_i),
    .word_ready_i (word_ready_i),
    .start_o      (start_o),
    .data_valid_o (data_valid_o),
    .last_o       (last_o),
    .abort_o      (abort_o),
    .data_o       (data_o),
    .opcode_o     (opcode_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          bp_mode = 0;
  int          xfer_cnt = 0;
  logic [33:0] exp_q[$];
  logic [7:0]  msg_b [0:127];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // word_ready_i: 0 = always ready, 1 = ~30% random duty, 2 = held low
  initial begin
    word_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (bp_mode)
        0:       word_ready_i = 1'b1;
        1:       word_ready_i = ($urandom_range(0, 99) < 30);
        default: word_ready_i = 1'b0;
      endcase
    end
  end

  always @(negedge clk_i) begin
    if (!aresetn_i) begin
      prev_stall <= 1'b0;
    end else begin
      if (data_valid_o && prev_stall)
        chk($sformatf("hold_word%0d", xfer_cnt), 64'({start_o, last_o, data_o}), 64'(prev_out));
      if (data_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL extra_word: got %h expected no word", data_o);
        end else begin
          chk($sformatf("word%0d", xfer_cnt), 64'({start_o, last_o, data_o}), 64'(exp_q.pop_front()));
        end
        xfer_cnt <= xfer_cnt + 1;
      end
      prev_stall <= data_valid_o && !word_ready_i;
      prev_out   <= {start_o, last_o, data_o};
    end
  end

  // Reference padding: message, 0x80, zeros, 64-bit big-endian bit count
  task automatic build_exp(input int len);
    int          nblk;
    int          tw;
    logic [63:0] bl;
    logic [7:0]  pb [0:191];
    nblk = (len + 8) / 64 + 1;
    tw   = len / 4;
    bl   = 64'(len) * 64'd8;
    for (int i = 0; i < nblk * 64; i++)
      pb[i] = (i < len) ? msg_b[i] : ((i == len) ? 8'h80 : 8'h00);
    for (int k = 0; k < 8; k++)
      pb[nblk * 64 - 8 + k] = bl[63 - 8 * k -: 8];
    for (int w = 0; w < nblk * 16; w++)
      exp_q.push_back({(w == 0), ((w / 16 == nblk - 1) && (w >= tw)),
                       pb[4 * w], pb[4 * w + 1], pb[4 * w + 2], pb[4 * w + 3]});
  endtask

  task automatic start_msg(input logic op);
    msg_start_i = 1'b1;
    opcode_i    = op;
    @(posedge clk_i);
    #1;
    msg_start_i = 1'b0;
    opcode_i    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] n);
    int guard;
    guard = 0;
    msg_valid_i  = 1'b1;
    msg_data_i   = d;
    msg_last_i   = last;
    msg_nbytes_i = n;
    forever begin
      @(negedge clk_i);
      if (msg_ready_o) break;
      guard++;
      if (guard > 2000) break;
    end
    chk("msg_accept_timeout", 64'(guard > 2000), 64'd0);
    @(posedge clk_i);
    #1;
    msg_valid_i = 1'b0;
    msg_last_i  = 1'b0;
  endtask

  function automatic logic [31:0] msg_word(input int w, input int len);
    logic [31:0] d;
    for (int k = 0; k < 4; k++)
      d[31 - 8 * k -: 8] = (4 * w + k < len) ? msg_b[4 * w + k] : 8'hEE;
    return d;
  endfunction

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || data_valid_o) && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_idle"}, 64'(msg_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_msg(input int len, input logic op, input string tag);
    int nw;
    build_exp(len);
    start_msg(op);
    chk({tag, "_opcode"}, 64'(opcode_o), 64'(op));
    nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++)
      send_word(msg_word(w, len), (w == nw - 1), (w == nw - 1) ? 3'(len - 4 * w) : 3'd4);
    wait_done(tag);
  endtask

  task automatic fill_pattern(input int len, input int seed);
    for (int i = 0; i < len; i++)
      msg_b[i] = 8'(i * 7 + seed);
  endtask

  task automatic fill_abc();
    msg_b[0] = 8'h61;
    msg_b[1] = 8'h62;
    msg_b[2] = 8'h63;
  endtask

  initial begin
    aresetn_i    = 1'b0;
    msg_start_i  = 1'b0;
    opcode_i     = 1'b0;
    msg_valid_i  = 1'b0;
    msg_data_i   = '0;
    msg_last_i   = 1'b0;
    msg_nbytes_i = '0;
    abort_i      = 1'b0;
    core_ready_i = 1'b1;
    bp_mode      = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_start",      64'(start_o),      64'd0);
    chk("rst_data_valid", 64'(data_valid_o), 64'd0);
    chk("rst_last",       64'(last_o),       64'd0);
    chk("rst_abort",      64'(abort_o),      64'd0);
    chk("rst_data",       64'(data_o),       64'd0);
    chk("rst_opcode",     64'(opcode_o),     64'd0);
    chk("rst_msg_ready",  64'(msg_ready_o),  64'd0);
    @(posedge clk_i);
    #1;
    aresetn_i = 1'b1;
    @(posedge clk_i);
    #1;

    fill_abc();
    run_msg(3, 1'b0, "abc");
    run_msg(0, 1'b1, "empty");
    fill_pattern(55, 3);
    run_msg(55, 1'b0, "len55");
    fill_pattern(56, 5);
    run_msg(56, 1'b1, "len56");
    fill_pattern(64, 9);
    run_msg(64, 1'b0, "len64");

    bp_mode = 1;
    fill_pattern(100, 11);
    run_msg(100, 1'b0, "bp100");
    fill_pattern(59, 17);
    run_msg(59, 1'b1, "bp59");
    bp_mode = 0;
    @(posedge clk_i);
    #1;

    // abort with word index 7 of block 1 held in the output register
    fill_pattern(48, 21);
    for (int w = 0; w < 7; w++)
      exp_q.push_back({(w == 0), 1'b0, msg_word(w, 48)});
    start_msg(1'b0);
    for (int w = 0; w < 7; w++)
      send_word(msg_word(w, 48), 1'b0, 3'd4);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++)
      @(negedge clk_i);
    chk("abort_pre_left", 64'(exp_q.size()), 64'd0);
    bp_mode = 2;
    @(posedge clk_i);
    #1;
    send_word(msg_word(7, 48), 1'b0, 3'd4);
    abort_i = 1'b1;
    @(negedge clk_i);
    chk("abort_pending_valid", 64'(data_valid_o), 64'd1);
    chk("abort_pending_pulse", 64'(abort_o), 64'd0);
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("abort_pulse",      64'(abort_o),      64'd1);
    chk("abort_data_valid", 64'(data_valid_o), 64'd0);
    chk("abort_last",       64'(last_o),       64'd0);
    chk("abort_start",      64'(start_o),      64'd0);
    chk("abort_idle",       64'(msg_ready_o),  64'd0);
    @(negedge clk_i);
    chk("abort_pulse_end",  64'(abort_o),      64'd0);
    chk("abort_no_word",    64'(exp_q.size()), 64'd0);
    bp_mode = 0;
    @(posedge clk_i);
    #1;
    fill_abc();
    run_msg(3, 1'b0, "abc_after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
